// File: rtl/hypercorex_inst_pkg.sv
// Shared types and constants for the instruction fetch controller.
package hypercorex_inst_pkg;

  // Fetch sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Default instruction memory depth.
  localparam int unsigned NumInstsDefault = 64;

endpackage

// File: rtl/inst_fetch_ctrl_mem_array.sv
// Register-file instruction memory: one synchronous write port and
// one asynchronous read port. Contents are not reset.
module inst_mem_array
  import hypercorex_inst_pkg::*;
#(
  parameter int unsigned InstWidth = 32,
  parameter int unsigned NumInsts  = NumInstsDefault,
  localparam int unsigned AddrWidth = $clog2(NumInsts)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [InstWidth-1:0] wr_data_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [InstWidth-1:0] rd_data_o
);

  logic [InstWidth-1:0] mem_q [NumInsts];

  // Write port: data lands on the clock edge after the strobe.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction sequencer for the decoder. It walks the PC from 0 to a
// programmed end address and repeats one hardware loop region.
//
// Handshake: in RUN the instruction at mem[pc] is offered every cycle.
// It counts as consumed (inst_en_o=1) only when stall_i=0 and stop_i=0,
// and only a consumed instruction advances the PC or the loop counter.
module inst_fetch_ctrl
  import hypercorex_inst_pkg::*;
#(
  parameter int unsigned InstWidth     = 32,
  parameter int unsigned NumInsts      = NumInstsDefault,
  parameter int unsigned LoopCntWidth  = 16,
  localparam int unsigned InstAddrWidth = $clog2(NumInsts)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     inst_wr_en_i,
  input  logic [InstAddrWidth-1:0] inst_wr_addr_i,
  input  logic [InstWidth-1:0]     inst_wr_data_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [InstAddrWidth-1:0] prog_end_addr_i,
  input  logic [InstAddrWidth-1:0] loop_start_addr_i,
  input  logic [InstAddrWidth-1:0] loop_end_addr_i,
  input  logic [LoopCntWidth-1:0]  loop_count_i,
  input  logic                     stall_i,
  output logic [InstWidth-1:0]     inst_code_o,
  output logic                     inst_en_o,
  output logic [InstAddrWidth-1:0] inst_pc_o,
  output logic                     busy_o,
  output logic                     done_o
);

  fetch_state_e             state_q, state_d;
  logic [InstAddrWidth-1:0] pc_q, pc_d;
  logic [LoopCntWidth-1:0]  iter_q, iter_d;
  logic [InstAddrWidth-1:0] prog_end_q, prog_end_d;
  logic [InstAddrWidth-1:0] loop_start_q, loop_start_d;
  logic [InstAddrWidth-1:0] loop_end_q, loop_end_d;
  // Last loop iteration index (effective count - 1); 0 means no repeat.
  logic [LoopCntWidth-1:0]  iter_max_q, iter_max_d;
  logic                     done_q, done_d;

  logic                     running;
  logic                     fire;
  logic                     loop_valid;
  logic                     mem_wr_en;
  logic [InstWidth-1:0]     mem_rd_data;

  assign running    = (state_q == ST_RUN);
  assign fire       = running & ~stall_i & ~stop_i;
  // A loop region that is inverted or reaches past the program end is ignored.
  assign loop_valid = (loop_start_addr_i <= loop_end_addr_i) &&
                      (loop_end_addr_i <= prog_end_addr_i);
  // Host writes are only honoured while the sequencer is idle.
  assign mem_wr_en  = inst_wr_en_i & ~running;

  inst_mem_array #(
    .InstWidth (InstWidth),
    .NumInsts  (NumInsts)
  ) i_mem (
    .clk_i     (clk_i),
    .wr_en_i   (mem_wr_en),
    .wr_addr_i (inst_wr_addr_i),
    .wr_data_i (inst_wr_data_i),
    .rd_addr_i (pc_q),
    .rd_data_o (mem_rd_data)
  );

  // Next-state logic: start/stop decisions, PC advance and loop handling.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    iter_d       = iter_q;
    prog_end_d   = prog_end_q;
    loop_start_d = loop_start_q;
    loop_end_d   = loop_end_q;
    iter_max_d   = iter_max_q;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d      = ST_RUN;
          pc_d         = '0;
          iter_d       = '0;
          prog_end_d   = prog_end_addr_i;
          loop_start_d = loop_start_addr_i;
          loop_end_d   = loop_end_addr_i;
          if (loop_valid && (loop_count_i != '0)) begin
            iter_max_d = loop_count_i - 1'b1;
          end else begin
            iter_max_d = '0;
          end
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          pc_d    = '0;
          iter_d  = '0;
        end else if (!stall_i) begin
          // Loop-back wins over program end when both addresses coincide.
          if ((pc_q == loop_end_q) && (iter_q < iter_max_q)) begin
            pc_d   = loop_start_q;
            iter_d = iter_q + 1'b1;
          end else if (pc_q == prog_end_q) begin
            state_d = ST_IDLE;
            pc_d    = '0;
            iter_d  = '0;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC, loop counter and latched configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= '0;
      iter_q       <= '0;
      prog_end_q   <= '0;
      loop_start_q <= '0;
      loop_end_q   <= '0;
      iter_max_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      iter_q       <= iter_d;
      prog_end_q   <= prog_end_d;
      loop_start_q <= loop_start_d;
      loop_end_q   <= loop_end_d;
      iter_max_q   <= iter_max_d;
      done_q       <= done_d;
    end
  end

  assign inst_code_o = running ? mem_rd_data : '0;
  assign inst_en_o   = fire;
  assign inst_pc_o   = pc_q;
  assign busy_o      = running;
  assign done_o      = done_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: straight runs, loops, stall,
// stop, reset, writes while running and invalid loop configurations.
module tb_inst_fetch_ctrl;

  localparam int W = 6;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          inst_wr_en_i;
  logic [W-1:0]  inst_wr_addr_i;
  logic [31:0]   inst_wr_data_i;
  logic          start_i;
  logic          stop_i;
  logic [W-1:0]  prog_end_addr_i;
  logic [W-1:0]  loop_start_addr_i;
  logic [W-1:0]  loop_end_addr_i;
  logic [15:0]   loop_count_i;
  logic          stall_i;
  logic [31:0]   inst_code_o;
  logic          inst_en_o;
  logic [W-1:0]  inst_pc_o;
  logic          busy_o;
  logic          done_o;

  inst_fetch_ctrl dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .inst_wr_en_i      (inst_wr_en_i),
    .inst_wr_addr_i    (inst_wr_addr_i),
    .inst_wr_data_i    (inst_wr_data_i),
    .start_i           (start_i),
    .stop_i            (stop_i),
    .prog_end_addr_i   (prog_end_addr_i),
    .loop_start_addr_i (loop_start_addr_i),
    .loop_end_addr_i   (loop_end_addr_i),
    .loop_count_i      (loop_count_i),
    .stall_i           (stall_i),
    .inst_code_o       (inst_code_o),
    .inst_en_o         (inst_en_o),
    .inst_pc_o         (inst_pc_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  // Clock and watchdog.
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state.
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_pc_q[$];
  logic [31:0]  obs_code_q[$];
  int           done_cycle;
  int           busy_cycles;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_inst(input logic [W-1:0] addr, input logic [31:0] data);
    inst_wr_en_i   = 1'b1;
    inst_wr_addr_i = addr;
    inst_wr_data_i = data;
    @(posedge clk_i); #1;
    inst_wr_en_i   = 1'b0;
  endtask

  task automatic set_cfg(input logic [W-1:0] pe, input logic [W-1:0] ls,
                         input logic [W-1:0] le, input logic [15:0] cnt);
    prog_end_addr_i   = pe;
    loop_start_addr_i = ls;
    loop_end_addr_i   = le;
    loop_count_i      = cnt;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_en"}, inst_en_o, 1'b0);
    check_eq({tag, "_code"}, inst_code_o, 32'h0);
    check_eq({tag, "_pc"}, inst_pc_o, '0);
    check_eq({tag, "_done"}, done_o, 1'b0);
  endtask

  // Runs one program to completion, logging every consumed PC/code.
  // Optionally stalls st_n cycles when the PC reaches st_pc, and
  // optionally tries a memory write in the first RUN cycle.
  task automatic run_prog(input string tag, input logic [W-1:0] pe, input logic [W-1:0] ls,
                          input logic [W-1:0] le, input logic [15:0] cnt,
                          input logic [W-1:0] st_pc, input int st_n, input logic wr_mid);
    int stall_left;
    set_cfg(pe, ls, le, cnt);
    obs_pc_q.delete();
    obs_code_q.delete();
    done_cycle  = 0;
    busy_cycles = 0;
    stall_left  = st_n;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (busy_o && (inst_pc_o == st_pc) && (stall_left > 0)) begin
        stall_i = 1'b1;
        stall_left--;
      end else begin
        stall_i = 1'b0;
      end
      if (wr_mid && (k == 1)) begin
        inst_wr_en_i   = 1'b1;
        inst_wr_addr_i = 6'd1;
        inst_wr_data_i = 32'hFF;
      end else begin
        inst_wr_en_i = 1'b0;
      end
      @(negedge clk_i);
      if (busy_o) busy_cycles++;
      if (stall_i) begin
        check_eq({tag, "_stall_en"}, inst_en_o, 1'b0);
        check_eq({tag, "_stall_pc"}, inst_pc_o, st_pc);
        check_eq({tag, "_stall_code"}, inst_code_o, 32'hA0 + st_pc);
      end
      if (inst_en_o) begin
        obs_pc_q.push_back(inst_pc_o);
        obs_code_q.push_back(inst_code_o);
      end
      if (done_o) begin
        done_cycle = k;
        break;
      end
      @(posedge clk_i); #1;
    end
    stall_i      = 1'b0;
    inst_wr_en_i = 1'b0;
    check_eq({tag, "_done_seen"}, (done_cycle != 0), 1'b1);
    check_eq({tag, "_busy_at_done"}, busy_o, 1'b0);
    // done must be a single-cycle pulse.
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_idle_outputs({tag, "_after"});
    @(posedge clk_i); #1;
  endtask

  task automatic compare_seq(input string tag);
    int n;
    check_eq({tag, "_len"}, obs_pc_q.size(), exp_q.size());
    n = (obs_pc_q.size() < exp_q.size()) ? obs_pc_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_pc%0d", tag, i), obs_pc_q[i], exp_q[i]);
      check_eq($sformatf("%s_code%0d", tag, i), obs_code_q[i], 32'hA0 + exp_q[i]);
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    inst_wr_en_i   = 1'b0;
    inst_wr_addr_i = '0;
    inst_wr_data_i = '0;
    start_i        = 1'b0;
    stop_i         = 1'b0;
    stall_i        = 1'b0;
    set_cfg(6'd0, 6'd0, 6'd0, 16'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("reset");
    @(posedge clk_i); #1;

    for (int i = 0; i < 4; i++) write_inst(W'(i), 32'hA0 + i);

    // Straight run: 4 enabled cycles then done on cycle 5.
    run_prog("straight", 6'd3, 6'd3, 6'd1, 16'd1, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3};
    compare_seq("straight");
    check_eq("straight_done_cycle", done_cycle, 5);
    check_eq("straight_busy_cycles", busy_cycles, 4);

    // Loop 1..2 executed 3 times.
    run_prog("loop3", 6'd3, 6'd1, 6'd2, 16'd3, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd1, 6'd2, 6'd1, 6'd2, 6'd3};
    compare_seq("loop3");
    check_eq("loop3_done_cycle", done_cycle, 9);

    // Count 0 behaves as a single pass.
    run_prog("loop0", 6'd3, 6'd1, 6'd2, 16'd0, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3};
    compare_seq("loop0");

    // Loop end equal to program end: loop-back takes priority.
    run_prog("loop_at_end", 6'd3, 6'd2, 6'd3, 16'd2, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd2, 6'd3};
    compare_seq("loop_at_end");

    // Stall two cycles at pc=2: six RUN cycles, done on the seventh.
    run_prog("stall", 6'd3, 6'd3, 6'd1, 16'd1, 6'd2, 2, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3};
    compare_seq("stall");
    check_eq("stall_busy_cycles", busy_cycles, 6);
    check_eq("stall_done_cycle", done_cycle, 7);

    // Stop at pc=1: enable drops immediately, IDLE next cycle, no done.
    set_cfg(6'd3, 6'd3, 6'd1, 16'd1);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    stop_i = 1'b1;
    @(negedge clk_i);
    check_eq("stop_pc", inst_pc_o, 6'd1);
    check_eq("stop_en", inst_en_o, 1'b0);
    check_eq("stop_busy", busy_o, 1'b1);
    @(posedge clk_i); #1;
    stop_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("stop_next");
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("stop_no_done", done_o, 1'b0);
    @(posedge clk_i); #1;

    // Reset at pc=2: everything reads 0 the following cycle.
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    check_eq("rst_mid_pc", inst_pc_o, 6'd2);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check_idle_outputs("rst_mid");
    @(posedge clk_i); #1;
    run_prog("after_rst", 6'd3, 6'd3, 6'd1, 16'd1, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3};
    compare_seq("after_rst");

    // Write during RUN is ignored, both in that run and in the next one.
    run_prog("wr_run", 6'd3, 6'd3, 6'd1, 16'd1, '1, 0, 1'b1);
    compare_seq("wr_run");
    run_prog("wr_rerun", 6'd3, 6'd3, 6'd1, 16'd1, '1, 0, 1'b0);
    compare_seq("wr_rerun");

    // start with stop in IDLE: stop wins.
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("start_stop_busy", busy_o, 1'b0);
    check_eq("start_stop_en", inst_en_o, 1'b0);
    start_i = 1'b0;
    stop_i  = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("start_stop_busy2", busy_o, 1'b0);
    @(posedge clk_i); #1;

    // Inverted loop region disables looping.
    run_prog("bad_loop", 6'd3, 6'd3, 6'd1, 16'd5, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2, 6'd3};
    compare_seq("bad_loop");

    // Loop end beyond program end disables looping.
    run_prog("loop_past_end", 6'd2, 6'd1, 6'd3, 16'd4, '1, 0, 1'b0);
    exp_q = '{6'd0, 6'd1, 6'd2};
    compare_seq("loop_past_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction sequencer that feeds the instruction decoder. It drives the decoder's instruction code and its enable.
- Holds a small programmable instruction memory, written by the host/CSR side while idle.
- Runs a program counter from address 0 to a programmed end address, with one hardware loop region repeated N times.
- Honours a downstream stall, e.g. an empty item-memory FIFO or an AM search that is still busy.

Parameters:
- InstWidth, 32, instruction word width; must match the decoder.
- NumInsts, 64, instruction memory depth.
- LoopCntWidth, 16, width of the loop iteration count.
- InstAddrWidth, $clog2(NumInsts), PC/address width. Derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- inst_wr_en_i  in  1  instruction memory write strobe.
- inst_wr_addr_i  in  InstAddrWidth  write address.
- inst_wr_data_i  in  InstWidth  write data.
- start_i  in  1  start program (level sampled in IDLE).
- stop_i  in  1  abort program.
- prog_end_addr_i  in  InstAddrWidth  last instruction address.
- loop_start_addr_i  in  InstAddrWidth  first address of the loop body.
- loop_end_addr_i  in  InstAddrWidth  last address of the loop body.
- loop_count_i  in  LoopCntWidth  total loop body executions; 0 is treated as 1.
- stall_i  in  1  downstream cannot accept an instruction this cycle.
- inst_code_o  out  InstWidth  instruction to the decoder.
- inst_en_o  out  1  decoder enable; the instruction is consumed this cycle.
- inst_pc_o  out  InstAddrWidth  current PC.
- busy_o  out  1  FSM in RUN.
- done_o  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE; PC, loop iteration counter and latched config are cleared to 0.
  - All outputs read 0 the cycle after rst_i is sampled high.
  - Memory contents are not reset.
  - Reset mid-RUN aborts immediately, with no done pulse.
- Memory:
  - Writes are accepted only in IDLE and land the next cycle.
  - inst_wr_en_i in RUN is ignored; memory is unchanged.
  - Reads are asynchronous: mem[pc].
- FSM states: IDLE, RUN.
- IDLE -> RUN:
  - Taken when start_i=1 and stop_i=0.
  - The same edge sets pc=0, iter=0 and latches prog_end, loop_start, loop_end and loop_count.
  - Loop is disabled (effective count 1) if loop_start > loop_end or loop_end > prog_end.
  - start_i together with stop_i in IDLE: stop wins, FSM stays in IDLE.
- RUN outputs:
  - inst_code_o = mem[pc]; inst_en_o = ~stall_i & ~stop_i.
  - Fetch has zero latency: the decoder sees the instruction in the cycle the PC points to it.
- RUN advance, only when inst_en_o=1:
  - If pc==loop_end and iter < eff_count-1: pc<=loop_start, iter<=iter+1.
  - Else if pc==prog_end: go to IDLE, done_o=1 for the next cycle, pc<=0.
  - Else: pc<=pc+1.
  - The loop check has priority over the end check when loop_end==prog_end.
- Stall: stall_i=1 drops inst_en_o and holds pc and iter. inst_code_o stays stable.
- Stop: stop_i in RUN drops inst_en_o the same cycle and returns to IDLE next cycle, with no done pulse.
- Outside RUN: inst_code_o=0, inst_en_o=0, busy_o=0.
- Arithmetic: iter is LoopCntWidth bits. eff_count = (loop_count==0) ? 1 : loop_count. PC increment never wraps past prog_end.

Decomposition:
- Add to hypercorex_inst_pkg:
  - state typedef (IDLE/RUN);
  - default depth constant NumInstsDefault.
- Sub-module inst_mem_array: register-file memory with 1 write port and 1 asynchronous read port, parameters InstWidth/NumInsts.
- inst_fetch_ctrl holds the FSM, PC, loop counter and output gating.

Test Plan:
- Straight run: write mem[0..3]=0xA0..0xA3, prog_end=3, loop disabled, start.
  - inst_en_o high 4 cycles with codes A0,A1,A2,A3.
  - done_o pulses on cycle 5; busy_o then 0.
- Loop: prog_end=3, loop 1..2, count=3.
  - PC sequence 0,1,2,1,2,1,2,3, i.e. 8 enabled cycles, then done.
  - count=0 gives sequence 0,1,2,3.
- Stall: same straight program with stall_i=1 for 2 cycles while pc=2.
  - inst_en_o=0 and pc stays 2 for those cycles; code 0xA2 stays stable.
  - Total 6 cycles to done.
- Stop/reset mid-run:
  - stop_i at pc=1: inst_en_o=0 that cycle, IDLE next cycle, no done_o.
  - Rerun, then rst_i at pc=2: all outputs 0 the next cycle, memory intact on a rerun.
- Write during RUN: write 0xFF to addr 1 while running.
  - Ignored: a later run still reads 0xA1.
  - start_i together with stop_i in IDLE leaves busy_o at 0.
- Invalid loop: loop_start=3, loop_end=1, count=5.
  - Loop is disabled; sequence 0..3 then done.
